// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_mux_pkg;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  // Channel-index width; never zero so a single-channel build still has a port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: rotate the doubled request vector by ptr, then
// priority-encode and map the offset back to an absolute channel index.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int RR   = 1,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [CH_W-1:0]   base;
  logic [CH_W-1:0]   off;
  int                sum;

  always_comb begin
    // Fixed priority is just round-robin pinned at base 0.
    base = '0;
    if (RR != 0 && int'(ptr) < N_CH) base = ptr;
    dbl = {req, req};
    rot = dbl[base +: N_CH];
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
    sum = int'(base) + int'(off);
    if (sum >= N_CH) sum = sum - N_CH;
    gnt_idx = CH_W'(sum);
    any_gnt = |req;
    gnt     = '0;
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_stream.sv
// N-channel valid/ready stream merger with a single registered output slot
// tagged by source channel; round-robin or fixed-priority arbitration.
module rr_mux_stream
  import rr_mux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W,
  parameter int RR   = 1,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0][W-1:0]    in_data,
  input  logic [N_CH-1:0]           in_valid,
  output logic [N_CH-1:0]           in_ready,
  output logic [W-1:0]              out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

  logic            load_en;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ptr_nxt;
  logic [CH_W-1:0] gnt_idx;
  logic [N_CH-1:0] gnt;
  logic            any_gnt;

  rr_arbiter #(.N_CH(N_CH), .RR(RR)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Slot can take a word when empty or being drained on this edge.
  assign load_en  = !out_valid || out_ready;
  assign in_ready = (rst_n && load_en) ? gnt : '0;
  assign ptr_nxt  = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt_idx];
        out_ch    <= gnt_idx;
        if (RR != 0) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_stream.sv
// Bench for rr_mux_stream: three builds (RR 4x8, fixed-priority 4x8, 1x16)
// checked every cycle against a queue-free behavioural model plus directed pins.
module tb_rr_mux_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  vld [3];
  logic [15:0] dat [3][4];
  logic        ordy [3];

  logic [3:0] a_rdy, b_rdy;
  logic [0:0] c_rdy;
  logic [7:0] a_data, b_data;
  logic [15:0] c_data;
  logic [1:0] a_ch, b_ch;
  logic [0:0] c_ch;
  logic a_v, b_v, c_v;

  rr_mux_stream #(.N_CH(4), .W(8), .RR(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data({dat[0][3][7:0], dat[0][2][7:0], dat[0][1][7:0], dat[0][0][7:0]}),
    .in_valid(vld[0]), .in_ready(a_rdy),
    .out_data(a_data), .out_ch(a_ch), .out_valid(a_v), .out_ready(ordy[0]));

  rr_mux_stream #(.N_CH(4), .W(8), .RR(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data({dat[1][3][7:0], dat[1][2][7:0], dat[1][1][7:0], dat[1][0][7:0]}),
    .in_valid(vld[1]), .in_ready(b_rdy),
    .out_data(b_data), .out_ch(b_ch), .out_valid(b_v), .out_ready(ordy[1]));

  rr_mux_stream #(.N_CH(1), .W(16), .RR(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(dat[2][0]),
    .in_valid(vld[2][0:0]), .in_ready(c_rdy),
    .out_data(c_data), .out_ch(c_ch), .out_valid(c_v), .out_ready(ordy[2]));

  logic [3:0]  ord [3];
  logic [15:0] od [3];
  logic [1:0]  och [3];
  logic        ov [3];
  always_comb begin
    ord[0] = a_rdy;  ord[1] = b_rdy;  ord[2] = {3'b0, c_rdy};
    od[0]  = {8'h0, a_data}; od[1] = {8'h0, b_data}; od[2] = c_data;
    och[0] = a_ch;   och[1] = b_ch;   och[2] = {1'b0, c_ch};
    ov[0]  = a_v;    ov[1]  = b_v;    ov[2]  = c_v;
  end

  int          nn [3] = '{4, 4, 1};
  bit          rrp [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] wm [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // First valid channel found scanning from the start point, wrapping over n.
  function automatic int pick(input logic [3:0] v, input int ptr, input int n, input bit rr);
    int c;
    for (int j = 0; j < n; j++) begin
      c = ((rr ? ptr : 0) + j) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Behavioural model: one holding slot per build, pointer = last winner + 1.
  bit          mv [3];
  logic [15:0] md [3];
  int          mc [3];
  int          mp [3];

  always @(posedge clk or negedge rst_n) begin : model
    int c;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] <= 1'b0; md[k] <= '0; mc[k] <= 0; mp[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        c = pick(vld[k], mp[k], nn[k], rrp[k]);
        if (!mv[k] || ordy[k]) begin
          if (c >= 0) begin
            mv[k] <= 1'b1;
            md[k] <= dat[k][c] & wm[k];
            mc[k] <= c;
            if (rrp[k]) mp[k] <= (c + 1) % nn[k];
          end else begin
            mv[k] <= 1'b0;
          end
        end
      end
    end
  end

  logic [3:0] xf [3];
  int sent = 0;
  int recv = 0;

  always @(negedge clk) begin : cmp
    int c;
    logic [3:0] er;
    for (int k = 0; k < 3; k++) begin
      c  = pick(vld[k], mp[k], nn[k], rrp[k]);
      er = (rst_n && (!mv[k] || ordy[k]) && c >= 0) ? (4'(1) << c) : 4'b0;
      chk($sformatf("dut%0d.out_valid", k), 32'(ov[k]), 32'(mv[k]));
      chk($sformatf("dut%0d.out_data", k), 32'(od[k]), 32'(md[k]));
      chk($sformatf("dut%0d.out_ch", k), 32'(och[k]), 32'(mc[k]));
      chk($sformatf("dut%0d.in_ready", k), 32'(ord[k]), 32'(er));
      xf[k] <= vld[k] & ord[k];
    end
    if (vld[2][0] && ord[2][0]) sent <= sent + 1;
    if (ov[2] && ordy[2]) recv <= recv + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = '0; ordy[k] = 1'b0; xf[k] = '0;
      for (int i = 0; i < 4; i++) dat[k][i] = '0;
    end
    step(); step();
    chk("rst.out_valid", 32'(a_v), 32'd0);
    rst_n = 1'b1;
    step();

    // Round-robin with all channels valid
    for (int i = 0; i < 4; i++) dat[0][i] = 16'(16'hA0 + i);
    vld[0] = 4'hF; ordy[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("rr.out_ch", 32'(a_ch), 32'(t % 4));
      chk("rr.out_data", 32'(a_data), 32'(8'hA0 + t % 4));
    end

    // Backpressure holds everything, then rotation resumes at channel 1
    ordy[0] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("bp.out_ch", 32'(a_ch), 32'd0);
      chk("bp.out_data", 32'(a_data), 32'hA0);
      chk("bp.in_ready", 32'(a_rdy), 32'd0);
    end
    ordy[0] = 1'b1;
    step();
    chk("bp.resume_ch", 32'(a_ch), 32'd1);

    // Sparse requests 1 and 3; pointer sits at 2 here
    vld[0] = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("sparse.out_ch", 32'(a_ch), (t % 2 == 0) ? 32'd3 : 32'd1);
    end
    vld[0] = 4'b0;
    step();
    chk("sparse.drain_valid", 32'(a_v), 32'd0);

    // Fixed priority: 0 always beats 2
    for (int i = 0; i < 4; i++) dat[1][i] = 16'(16'h10 + i);
    vld[1] = 4'b0101; ordy[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("fp.out_ch", 32'(b_ch), 32'd0);
      chk("fp.in_ready", 32'(b_rdy), 32'b0001);
    end
    vld[1] = 4'b0100;
    step();
    chk("fp.ch2_ch", 32'(b_ch), 32'd2);
    chk("fp.ch2_data", 32'(b_data), 32'h12);
    vld[1] = 4'b0;
    step();

    // Single channel, 16 bits
    dat[2][0] = 16'hBEEF; vld[2] = 4'b1; ordy[2] = 1'b1;
    step();
    vld[2] = 4'b0;
    chk("one.out_valid", 32'(c_v), 32'd1);
    chk("one.out_data", 32'(c_data), 32'hBEEF);
    chk("one.out_ch", 32'(c_ch), 32'd0);
    step();
    chk("one.idle_valid", 32'(c_v), 32'd0);

    // Async reset while a word is stalled in the slot
    vld[0] = 4'hF; ordy[0] = 1'b0;
    step();
    chk("rstmid.loaded_valid", 32'(a_v), 32'd1);
    chk("rstmid.loaded_ch", 32'(a_ch), 32'd2);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.out_valid", 32'(a_v), 32'd0);
    chk("rstmid.out_data", 32'(a_data), 32'd0);
    chk("rstmid.out_ch", 32'(a_ch), 32'd0);
    chk("rstmid.in_ready", 32'(a_rdy), 32'd0);
    step();
    rst_n = 1'b1; ordy[0] = 1'b1;
    step();
    chk("rstmid.first_ch", 32'(a_ch), 32'd0);
    chk("rstmid.first_data", 32'(a_data), 32'hA0);
    for (int k = 0; k < 3; k++) vld[k] = '0;
    step();

    // Random traffic; producers hold each word until it is taken
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < nn[k]; i++) begin
          if (!vld[k][i] || xf[k][i]) begin
            vld[k][i] = 1'($urandom_range(0, 1));
            dat[k][i] = 16'($urandom) & wm[k];
          end
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      vld[k] = '0; ordy[k] = 1'b1;
    end
    step(); step(); step();
    chk("one.scoreboard", 32'(recv), 32'(sent));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux_stream.md
# rr_mux_stream

Parametrised N-channel, W-bit registered multiplexer that generalises the 2:1 select mux into a stream merger. Each cycle it picks one requesting input channel (round-robin or fixed priority), transfers its word into a single output register, and tags it with the source channel index. It sits wherever several valid/ready producers share one consumer, for example sample streams feeding a single DSP datapath.

## Interface
- N_CH, 4, number of input channels (≥1)
- W, 8, data width in bits (≥1)
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N_CH×W  channel data, packed unpacked-array `[N_CH][W]`
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready, at most one bit high per cycle
- out_data  output  W  registered selected word
- out_ch  output  CH_W  index of the channel that supplied out_data; CH_W = max(1, $clog2(N_CH))
- out_valid  output  1  output holds an unconsumed word
- out_ready  input  1  consumer accepts word

One clock; reset is asynchronous and active-low.

## Operation
- load_en = !out_valid || out_ready (register empty, or draining this cycle).
- grant: one-hot over in_valid. RR=1: search starts at ptr and wraps modulo N_CH; RR=0: lowest set index.
- in_ready[i] = load_en && grant[i]. An input transfer occurs on in_valid[i] && in_ready[i].
- On transfer: out_data <= in_data[i], out_ch <= i, out_valid <= 1; if RR=1, ptr <= (i+1) mod N_CH.
- load_en with no in_valid set: out_valid <= 0 (out_data/out_ch hold their last value).
- !load_en (out_valid && !out_ready): all outputs hold; all in_ready = 0; ptr holds.
- Ptr advances only on a transfer, never on idle or stall cycles.
- N_CH=1: grant = in_valid[0]; ptr constant 0; out_ch constant 0.
- Reset (asynchronous assert, any time including mid-stall): out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready=0 while rst_n=0. A pending word is discarded. Deassertion is synchronised externally.

## Timing
- Latency: 1 cycle from input transfer edge to out_valid visible.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- in_ready combinationally depends on in_valid, out_valid, out_ready and ptr. There is no path from in_data to in_ready.
- Simultaneous drain and fill (out_valid && out_ready && any in_valid) replaces the word in the same edge, with no bubble.
- Fairness (RR=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0,… Any valid channel waits at most N_CH-1 transfers.
- A stalled producer must hold in_valid/in_data until its transfer. The block does not check this.

## Structure
- Package rr_mux_pkg: function ch_w(n) returning max(1, $clog2(n)); default N_CH/W constants.
- Sub-module rr_arbiter (N_CH, RR): inputs req[N_CH], ptr[CH_W]; outputs one-hot gnt[N_CH], gnt_idx[CH_W], any_gnt. Purely combinational, implemented as a doubled-vector rotate-and-priority-encode.
- Top rr_mux_stream holds the output register, ptr register and load_en logic, and instances rr_arbiter once.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_ch, in_ready all 0 immediately. After release, the first grant goes to channel 0.
- RR=1, N_CH=4, W=8, all valid with data 8'hA0+i, out_ready=1 -> out_ch sequence 0,1,2,3,0, out_data A0,A1,A2,A3,A0, one word per cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch stable, in_ready=0000, ptr unchanged. On release, the next grant continues the rotation.
- Sparse requests: only channels 1 and 3 valid, RR=1 -> alternates 1,3,1,3. Dropping all valid -> out_valid falls after the final drain.
- RR=0, channels 0 and 2 continuously valid -> channel 0 granted every cycle, channel 2 never. Dropping ch0 valid -> channel 2 granted on the next cycle.
- N_CH=1, W=16: in_data 16'hBEEF, valid pulse -> out_valid one cycle later with BEEF, out_ch=0. Random valid/ready test -> scoreboard confirms no loss or duplication.
